// File: rtl/peripheral_ahb3_sram_slave.sv
// AHB-Lite (AMBA3) slave with an internal word-organised SRAM.
// Supports byte/halfword/word lane writes, programmable wait states and two-cycle ERROR responses.
module peripheral_ahb3_sram_slave #(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES  = HDATA_SIZE / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LANE_W-1:0]     lane_r;
    logic [IDX_W-1:0]      idx_r;
    logic [2:0]            size_r;
    logic                  write_r;
    logic [3:0]            wait_cnt;
    logic [BYTES-1:0]      byte_en;
    logic                  addr_phase_open;
    logic                  accept;
    logic                  req_err;
    logic                  unused_ok;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    // Burst type, protection and lock carry no meaning for a plain RAM.
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    function automatic logic transfer_error(input logic [HADDR_SIZE-1:0] addr,
                                            input logic [2:0]            size);
        logic [63:0] a;
        logic [63:0] nbytes;
        a      = 64'(addr);
        nbytes = 64'd1 << size;
        return ((a >> LANE_W) >= 64'(MEM_DEPTH))
            || ((a & (nbytes - 64'd1)) != 64'd0)
            || ((nbytes << 3) > 64'(HDATA_SIZE));
    endfunction

    // A new address phase may only be taken while no data phase of ours is stalling the bus.
    assign addr_phase_open = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept          = HSEL && HREADY && HTRANS[1] && addr_phase_open;
    assign req_err         = transfer_error(HADDR, HSIZE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_DATA;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (!accept) begin
                    state_nxt = S_IDLE;
                end else if (req_err) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_DATA;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            S_WAIT: HREADYOUT = 1'b0;
            S_DATA: begin
                if (!write_r) begin
                    HRDATA = mem[idx_r];
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (accept && !req_err) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Address-phase controls are only consumed under the FSM's guard, so they need no reset.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            lane_r  <= HADDR[LANE_W-1:0];
            idx_r   <= HADDR[LANE_W +: IDX_W];
            size_r  <= HSIZE;
            write_r <= HWRITE;
        end
    end

    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            byte_en[b] = (b >= int'(lane_r)) && (b < int'(lane_r) + (1 << size_r));
        end
    end

    always_ff @(posedge HCLK) begin
        if ((state == S_DATA) && write_r) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) begin
                    mem[idx_r][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_peripheral_ahb3_sram_slave.sv
// Pipelined AHB-Lite master driving two SRAM slaves (0 and 2 wait states) against a byte-level scoreboard.
module tb_peripheral_ahb3_sram_slave;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    typedef struct {
        int          waits;
        logic        resp;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel0;
    logic        hsel2;
    logic [15:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] rdata0;
    logic [31:0] rdata2;
    logic        ro0;
    logic        ro2;
    logic        resp0;
    logic        resp2;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [7:0]  bmem[int];
    logic [31:0] dp_wdata;

    assign HREADY = ro0 & ro2;
    assign HRDATA = rdata0 | rdata2;
    assign HRESP  = resp0 | resp2;

    always #5 HCLK = ~HCLK;

    peripheral_ahb3_sram_slave #(
        .HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata0), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(ro0), .HRESP(resp0)
    );

    peripheral_ahb3_sram_slave #(
        .HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(2)
    ) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata2), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(ro2), .HRESP(resp2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t idle_exp(input string tag);
        exp_t e;
        e.waits = 0;
        e.resp  = 1'b0;
        e.rdata = 32'h0;
        e.tag   = tag;
        return e;
    endfunction

    // Drive one address phase (sel: 0 = none, 1 = zero-wait slave, 2 = two-wait slave),
    // finish the previous data phase against the scoreboard, then push this beat's expectation.
    task automatic issue(input int sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic err, input string tag);
        exp_t cur;
        exp_t nxt;
        int   waits;
        int   a;
        int   key;
        logic have;
        hsel0  = (sel == 1);
        hsel2  = (sel == 2);
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HWDATA = dp_wdata;
        have   = 1'b1;
        cur    = idle_exp("none");
        if (sb.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
            have = 1'b0;
        end else begin
            cur = sb.pop_front();
        end
        waits = 0;
        forever begin
            @(negedge HCLK);
            if (HREADY) break;
            waits++;
            if (have) begin
                check_val({cur.tag, ".wait_resp"}, 32'(HRESP), 32'(cur.resp));
                check_val({cur.tag, ".wait_rdata"}, HRDATA, 32'h0);
            end
            if (waits > 20) begin
                check_val({cur.tag, ".timeout"}, 32'(waits), 32'd20);
                break;
            end
        end
        if (have) begin
            check_val({cur.tag, ".waits"}, 32'(waits), 32'(cur.waits));
            check_val({cur.tag, ".resp"}, 32'(HRESP), 32'(cur.resp));
            check_val({cur.tag, ".rdata"}, HRDATA, cur.rdata);
        end
        @(posedge HCLK);
        #1;
        nxt = idle_exp(tag);
        a   = int'(addr);
        if ((sel != 0) && trans[1]) begin
            if (err) begin
                nxt.waits = 1;
                nxt.resp  = 1'b1;
            end else begin
                nxt.waits = (sel == 2) ? 2 : 0;
                if (wr) begin
                    for (int k = 0; k < (1 << size); k++) begin
                        key       = sel * 65536 + a + k;
                        bmem[key] = wdata[((a + k) % 4) * 8 +: 8];
                    end
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        key = sel * 65536 + (a & ~3) + k;
                        nxt.rdata[k*8 +: 8] = bmem.exists(key) ? bmem[key] : 8'h00;
                    end
                end
            end
        end
        sb.push_back(nxt);
        dp_wdata = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn   = 1'b0;
        hsel0     = 1'b0;
        hsel2     = 1'b0;
        HADDR     = '0;
        HWDATA    = '0;
        HWRITE    = 1'b0;
        HSIZE     = 3'd2;
        HBURST    = 3'd0;
        HPROT     = 4'b0011;
        HTRANS    = T_IDLE;
        HMASTLOCK = 1'b0;
        dp_wdata  = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check_val("reset.ready0", 32'(ro0), 32'd1);
        check_val("reset.ready2", 32'(ro2), 32'd1);
        check_val("reset.resp", 32'(HRESP), 32'd0);
        check_val("reset.rdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        sb.push_back(idle_exp("post_reset"));

        // Word access, zero wait states, including the last legal word.
        issue(1, T_NONSEQ, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, 1'b0, "w_0010");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0010, 32'h0, 1'b0, "r_0010");
        issue(1, T_NONSEQ, 1'b1, 3'd2, 16'h03FC, 32'h0BADF00D, 1'b0, "w_03fc");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h03FC, 32'h0, 1'b0, "r_03fc");
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle0");

        // Byte lanes: expect 0xBBCCAA44 at 0x20.
        issue(1, T_NONSEQ, 1'b1, 3'd2, 16'h0020, 32'h11223344, 1'b0, "w_word20");
        issue(1, T_NONSEQ, 1'b1, 3'd0, 16'h0021, 32'h0000AA00, 1'b0, "w_byte21");
        issue(1, T_NONSEQ, 1'b1, 3'd1, 16'h0022, 32'hBBCC0000, 1'b0, "w_half22");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0020, 32'h0, 1'b0, "r_lanes20");
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle1");

        // INCR4 with two wait states per beat.
        HBURST = 3'b011;
        for (int i = 0; i < 4; i++) begin
            issue(2, (i == 0) ? T_NONSEQ : T_SEQ, 1'b1, 3'd2, 16'(16'h0040 + 4 * i),
                  32'(i + 1), 1'b0, $sformatf("incr4_w%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            issue(2, (i == 0) ? T_NONSEQ : T_SEQ, 1'b0, 3'd2, 16'(16'h0040 + 4 * i),
                  32'h0, 1'b0, $sformatf("incr4_r%0d", i));
        end
        HBURST = 3'b000;
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle2");

        // Error responses; the beat issued during ERR2 must complete normally.
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0400, 32'h0, 1'b1, "err_range");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0010, 32'h0, 1'b0, "r_after_err");
        issue(1, T_NONSEQ, 1'b1, 3'd1, 16'h0011, 32'h77660000, 1'b1, "err_misalign");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0010, 32'h0, 1'b0, "r_unchanged10");
        issue(1, T_NONSEQ, 1'b0, 3'd3, 16'h0018, 32'h0, 1'b1, "err_toowide");
        issue(2, T_NONSEQ, 1'b0, 3'd2, 16'h0400, 32'h0, 1'b1, "err_range_w2");
        issue(2, T_NONSEQ, 1'b0, 3'd2, 16'h0044, 32'h0, 1'b0, "r_after_err_w2");
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle3");

        // BUSY inside a burst and IDLE with HSEL high: OKAY, no wait, no write.
        HBURST = 3'b001;
        issue(1, T_NONSEQ, 1'b1, 3'd2, 16'h0030, 32'hCAFEF00D, 1'b0, "w_0030");
        issue(1, T_BUSY, 1'b1, 3'd2, 16'h0030, 32'h99999999, 1'b0, "busy");
        issue(1, T_IDLE, 1'b1, 3'd2, 16'h0030, 32'hFFFFFFFF, 1'b0, "idle_sel");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0030, 32'h0, 1'b0, "r_0030");
        HBURST = 3'b000;
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle4");

        // Asynchronous reset while a write beat is waiting: it must be dropped.
        issue(2, T_NONSEQ, 1'b1, 3'd2, 16'h0080, 32'h55555555, 1'b0, "w_pre80");
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle5");
        hsel2  = 1'b1;
        HTRANS = T_NONSEQ;
        HWRITE = 1'b1;
        HSIZE  = 3'd2;
        HADDR  = 16'h0080;
        HWDATA = dp_wdata;
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
        hsel2  = 1'b0;
        HTRANS = T_IDLE;
        HWDATA = 32'hA5A5A5A5;
        @(negedge HCLK);
        check_val("rst_mid.in_wait", 32'(ro2), 32'd0);
        HRESETn = 1'b0;
        #1;
        check_val("rst_mid.ready", 32'(ro2), 32'd1);
        check_val("rst_mid.resp", 32'(resp2), 32'd0);
        check_val("rst_mid.rdata", rdata2, 32'h0);
        sb.delete();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        sb.push_back(idle_exp("post_reset2"));
        dp_wdata = '0;
        issue(2, T_NONSEQ, 1'b0, 3'd2, 16'h0080, 32'h0, 1'b0, "r_80_kept");
        issue(1, T_NONSEQ, 1'b0, 3'd2, 16'h0020, 32'h0, 1'b0, "r_20_kept");
        issue(0, T_IDLE, 1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, "idle6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peripheral_ahb3_sram_slave.md
Name: peripheral_ahb3_sram_slave

Overview:
- AMBA3 AHB-Lite slave (responder) with an internal word-organised memory.
- Accepts single and burst transfers from the MPSoC AHB3 master/BFM.
- Supports byte/halfword/word writes with lane selection, programmable wait states and two-cycle ERROR responses.
- Used as a bench target and as a simple on-chip RAM behind the AHB3 interconnect.

Parameters:
- HADDR_SIZE, 16, address bus width.
- HDATA_SIZE, 32, data bus width: 32 or 64.
- MEM_DEPTH, 256, number of HDATA_SIZE-wide words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase: 0..15.

Ports:
- HCLK  in  1  clock, rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data, valid in the data phase.
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored, each beat decoded independently.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-wide ready, which qualifies the address phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Address phase is accepted on the rising edge when HSEL & HREADY & HTRANS[1]. On acceptance, register addr, size and write, and compute err.
- err=1 when any of these holds:
  - word index (addr / (HDATA_SIZE/8)) >= MEM_DEPTH;
  - addr not aligned to 2^HSIZE bytes;
  - 2^HSIZE*8 > HDATA_SIZE.
- IDLE or BUSY with HSEL, and any cycle with HSEL=0: no access; the next data phase is OKAY with zero wait states.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2. Transitions on accepted transfer:
  - err=1 -> ERR1.
  - WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1.
  - otherwise -> DATA.
- WAIT: HREADYOUT=0, HRESP=0. Decrement the counter; move to DATA when it reaches 0.
- DATA: HREADYOUT=1, HRESP=0. The data phase completes this cycle. The next state is decided by the address-phase sample in the same cycle, which allows back-to-back pipelining; with no new transfer -> IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Next -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1. The address phase sampled in this cycle is evaluated normally. A master that cancels with IDLE is legal.
- In IDLE, HREADYOUT=1 and HRESP=0.
- Write commit:
  - Only in the DATA cycle, at the rising edge.
  - Only lanes [lane_off*8 +: 2^HSIZE*8] are updated from HWDATA, where lane_off = addr % (HDATA_SIZE/8). Other lanes are unchanged.
  - Errored or waiting cycles never write.
- Read data:
  - During DATA of a read, HRDATA = full memory word at the registered index, combinational from the array. The master extracts lanes.
  - HRDATA=0 in all other cycles, including ERR1/ERR2.
- Write-then-read to the same address back-to-back returns the new data. The write commits at the end of the write DATA cycle, and the read DATA follows at least one cycle later.
- Latency with WAIT_STATES=W: the data phase lasts W+1 cycles; ERROR always lasts 2 cycles.
- Asynchronous reset mid-transfer: outputs return to reset values immediately, the pending write is dropped, and the FSM goes to IDLE.

Test Plan:
- Reset: assert HRESETn=0 mid-burst -> HREADYOUT=1, HRESP=0, HRDATA=0 in the same cycle; no memory update occurs.
- Word access, W=0: single write 0xDEADBEEF @0x0010, then single read @0x0010 -> HRDATA=0xDEADBEEF in the read data phase, HREADYOUT never low.
- Byte lanes: write word 0x11223344 @0x20, then byte 0xAA @0x21 (HWDATA=0x0000AA00), then halfword 0xBBCC @0x22 (HWDATA=0xBBCC0000) -> read @0x20 returns 0xBBCCAA44.
- Wait states and INCR4: WAIT_STATES=2, INCR4 write of 1,2,3,4 @0x40 -> each beat shows HREADYOUT low for 2 cycles then high; INCR4 read returns 1,2,3,4; each beat takes 3 cycles.
- Error response:
  - Read @ MEM_DEPTH*4 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), HRDATA=0.
  - Halfword write @0x0011 (misaligned) -> same two-cycle ERROR, memory @0x10 unchanged.
- IDLE/BUSY: HTRANS=BUSY inside a burst and HTRANS=IDLE with HSEL=1 -> OKAY, zero wait, no memory change. A NONSEQ issued during ERR2 is accepted and completes normally.
